// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that forces rotation away from a long-running winner.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       gnt_idx_q, gnt_idx_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [2:0]       rel_ptr;
  logic [3:0]       win_ptr;
  logic [3:0]       win_rel;

  // Returns {found, index}: first set request bit scanning upward from p, wrapping at 7.
  function automatic logic [3:0] search(input logic [7:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] idx;
    logic [2:0] w;
    found = 1'b0;
    w     = p;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    return {found, w};
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    rel_ptr = gnt_idx_q + 3'd1;
    win_ptr = search(req, ptr_q);
    win_rel = search(req, rel_ptr);

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_ptr[3]) begin
          state_d             = GRANT;
          gnt_d[win_ptr[2:0]] = 1'b1;
          gnt_idx_d           = win_ptr[2:0];
          hold_cnt_d          = '0;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        // Release is checked first so a release on the limit edge never pulses timeout.
        if (!req[gnt_idx_q]) begin
          ptr_d      = rel_ptr;
          hold_cnt_d = '0;
          gnt_d      = '0;
          if (win_rel[3]) begin
            gnt_d[win_rel[2:0]] = 1'b1;
            gnt_idx_d           = win_rel[2:0];
          end else begin
            state_d = IDLE;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          timeout_d           = 1'b1;
          ptr_d               = rel_ptr;
          hold_cnt_d          = '0;
          gnt_d               = '0;
          gnt_d[win_rel[2:0]] = 1'b1;
          gnt_idx_d           = win_rel[2:0];
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Eight-requester round-robin arbiter that shares one resource (e.g. a bus or datapath port) between up to eight clients. Priority selection is the team's 8-to-3 encoder rule (lowest index wins) applied relative to a rotating pointer. Grants are registered and held while the winner keeps requesting. An optional hold limit forces rotation so no client can starve the others.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one grant may last; 0 = unlimited, no forced rotation
CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
req  input  8  request vector, bit i = requester i
gnt  output  8  one-hot grant, registered
gnt_idx  output  3  binary index of the granted requester, registered
gnt_valid  output  1  high while any grant is active; equals |gnt
timeout  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD

Behaviour:
- Reset: rst_n low asynchronously clears all state. gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Winner search: examine req bits in order ptr, ptr+1, … ptr+7, modulo 8. The first set bit wins. Indices are 3-bit and wrap 7 -> 0.
- FSM states: IDLE and GRANT.
- IDLE:
  - req==0: remain in IDLE, all outputs 0.
  - Any req bit set: on the next edge, register the winner (gnt=1<<w, gnt_idx=w, gnt_valid=1), set hold_cnt=0 and go to GRANT.
  - Latency is one cycle from req sampled to gnt visible.
- GRANT: hold_cnt increments each cycle. End conditions are evaluated at each edge, in this priority:
  1. Release, when req[gnt_idx]==0:
     - Set ptr=gnt_idx+1.
     - If another req bit is set, grant the new winner on the same edge (searched from the new ptr), with no idle cycle, and clear hold_cnt.
     - Otherwise clear gnt/gnt_valid and go to IDLE. gnt_idx keeps its last value.
     - timeout stays 0.
  2. Timeout, when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with req[gnt_idx] still 1:
     - Pulse timeout=1 for exactly one cycle, coincident with the new grant.
     - Set ptr=gnt_idx+1 and search the current req.
     - If the same requester is the only one requesting, it wins again: gnt remains continuously high, hold_cnt restarts at 0 and timeout still pulses.
  3. Otherwise: hold the grant unchanged.
- A grant therefore lasts at most MAX_HOLD cycles.
- Release and timeout on the same edge: release wins and timeout is not pulsed.
- req bits other than the granted one do not affect an active grant.
- gnt is always one-hot or zero. gnt_valid==|gnt at all times.
- Async reset mid-grant drops gnt immediately, without waiting for clk. After rst_n rises, arbitration restarts from ptr=0.

Test Plan:
1. Reset: hold rst_n=0, req=8'hFF, clk running -> gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0.
2. Single requester:
   - After reset, req=8'b0000_1000 -> one edge later gnt=8'h08, gnt_idx=3, gnt_valid=1.
   - Held for 5 cycles, then req=0 -> next edge gnt=0, gnt_valid=0.
3. Full contention (MAX_HOLD=16): req=8'hFF, and each granted requester drops its bit 2 cycles after its grant and re-raises it one cycle later -> grant order 0,1,2,…,7,0, each grant back-to-back with no idle cycle.
4. Pointer wrap:
   - Grant 3, then release it so ptr=4.
   - Then req=8'b0000_1001 -> next grant is index 0, not 3.
   - Release 0, then req=8'b0000_1001 again -> grant 3.
5. Forced rotation (MAX_HOLD=4): req=8'b0000_0110 held constant -> gnt_idx sequence 1,1,1,1,2,2,2,2,1,…, with timeout pulsed one cycle at each switch.
6. Self re-grant and async reset (MAX_HOLD=4):
   - req=8'h01 constant -> gnt=8'h01 continuously; timeout pulses every 4 cycles.
   - Assert rst_n=0 between clock edges -> gnt=0 immediately, with no edge needed.
